mips_multicycle_ctrl: RTL and testbench

//  Multi-cycle MIPS control FSM driving the datapath around the ALU. Generates ALU_Func and

---
 rtl/mips_multicycle_ctrl.sv | 249 ++++++++++++++++++++++++
 tb/tb_mips_multicycle_ctrl.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mips_multicycle_ctrl.sv
// Multi-cycle MIPS control unit. Sequences each instruction through
// fetch/decode/execute/memory/writeback, drives the ALU function code and
// datapath selects, waits on the memory ready handshake, and raises the
// overflow / illegal-instruction exception.
module mips_multicycle_ctrl #(
    parameter bit EXC_ON_OVF     = 1'b1,
    parameter bit EXC_ON_ILLEGAL = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] Instr,
    input  logic        ALU_Zero,
    input  logic        ALU_OverFlow,
    input  logic        Mem_Ready,
    output logic [3:0]  ALU_Func,
    output logic        ALUSrcA,
    output logic [1:0]  ALUSrcB,
    output logic        ExtSel,
    output logic        Mem_Read,
    output logic        Mem_Write,
    output logic        IorD,
    output logic        IR_Write,
    output logic        PC_Write,
    output logic [1:0]  PC_Src,
    output logic        Reg_Write,
    output logic        RegDst,
    output logic        MemToReg,
    output logic        EPC_Write,
    output logic [1:0]  Exc_Cause,
    output logic [3:0]  State
);

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,  S_DECODE = 4'd1,  S_MEMADR = 4'd2,  S_MEMRD = 4'd3,
        S_MEMWB  = 4'd4,  S_MEMWR  = 4'd5,  S_RTEXE  = 4'd6,  S_ITEXE = 4'd7,
        S_ALUWB  = 4'd8,  S_BRANCH = 4'd9,  S_JUMP   = 4'd10, S_EXC   = 4'd11
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'h00, OP_J     = 6'h02, OP_BEQ  = 6'h04,
                           OP_BNE   = 6'h05, OP_ADDI  = 6'h08, OP_ADDIU = 6'h09,
                           OP_SLTI  = 6'h0A, OP_SLTIU = 6'h0B, OP_ANDI = 6'h0C,
                           OP_ORI   = 6'h0D, OP_XORI  = 6'h0E, OP_LUI  = 6'h0F,
                           OP_LW    = 6'h23, OP_SW    = 6'h2B;

    localparam logic [3:0] F_PASSB = 4'b0000, F_ADDU = 4'b0001, F_ADD  = 4'b0010,
                           F_SUBU  = 4'b0011, F_SUB  = 4'b0100, F_AND  = 4'b0101,
                           F_OR    = 4'b0110, F_NOR  = 4'b0111, F_XOR  = 4'b1000,
                           F_SLTU  = 4'b1001, F_SLT  = 4'b1010;

    state_t     state, next_state;
    logic       ovf_q;
    logic [5:0] opcode, funct;
    logic [3:0] r_func, i_func;
    logic       r_legal, i_ext;
    logic       ovf_trap;
    state_t     illegal_next;
    logic       unused_instr_bits;

    assign opcode            = Instr[31:26];
    assign funct             = Instr[5:0];
    assign unused_instr_bits = ^Instr[25:6];
    assign ovf_trap          = ovf_q & EXC_ON_OVF;
    assign illegal_next      = EXC_ON_ILLEGAL ? S_EXC : S_FETCH;
    assign State             = state;

    // Instruction field decode: ALU function for R-type funct and I-type opcode
    always_comb begin
        // NOTE: every output of a combinational block gets a default first so no path leaves it unassigned (which would infer a latch).
        r_func  = F_PASSB;
        r_legal = 1'b1;
        i_func  = F_ADDU;
        i_ext   = 1'b1;
        case (funct)
            6'h20:   r_func = F_ADD;
            6'h21:   r_func = F_ADDU;
            6'h22:   r_func = F_SUB;
            6'h23:   r_func = F_SUBU;
            6'h24:   r_func = F_AND;
            6'h25:   r_func = F_OR;
            6'h26:   r_func = F_XOR;
            6'h27:   r_func = F_NOR;
            6'h2A:   r_func = F_SLT;
            6'h2B:   r_func = F_SLTU;
            default: r_legal = 1'b0;
        endcase
        case (opcode)
            OP_ADDI:  i_func = F_ADD;
            OP_ADDIU: i_func = F_ADDU;
            OP_ANDI:  begin i_func = F_AND;   i_ext = 1'b0; end
            OP_ORI:   begin i_func = F_OR;    i_ext = 1'b0; end
            OP_XORI:  begin i_func = F_XOR;   i_ext = 1'b0; end
            OP_SLTI:  i_func = F_SLT;
            OP_SLTIU: i_func = F_SLTU;
            OP_LUI:   begin i_func = F_PASSB; i_ext = 1'b0; end
            default:  i_func = F_ADDU;
        endcase
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: sequential state is updated with non-blocking assignments so every flop samples pre-edge values.
        if (rst) state <= S_FETCH;
        else     state <= next_state;
    end

    // Overflow flag captured at the end of execute, cleared on each fetch
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            ovf_q <= 1'b0;
        else if (state == S_FETCH)
            ovf_q <= 1'b0;
        else if (state == S_RTEXE || state == S_ITEXE)
            ovf_q <= ALU_OverFlow & (ALU_Func == F_ADD || ALU_Func == F_SUB);
    end

    // Exception cause latched on entry to EXC and held until the next exception
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            Exc_Cause <= 2'b00;
        else if (next_state == S_EXC)
            Exc_Cause <= (state == S_ALUWB) ? 2'b01 : 2'b10;
    end

    // Next-state selection
    always_comb begin
        next_state = S_FETCH;
        case (state)
            S_FETCH:  next_state = Mem_Ready ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (opcode)
                    OP_LW, OP_SW:     next_state = S_MEMADR;
                    OP_RTYPE:         next_state = S_RTEXE;
                    OP_ADDI, OP_ADDIU, OP_ANDI, OP_ORI,
                    OP_XORI, OP_SLTI, OP_SLTIU, OP_LUI:
                                      next_state = S_ITEXE;
                    OP_BEQ, OP_BNE:   next_state = S_BRANCH;
                    OP_J:             next_state = S_JUMP;
                    default:          next_state = illegal_next;
                endcase
            end
            S_MEMADR: next_state = (opcode == OP_LW) ? S_MEMRD : S_MEMWR;
            S_MEMRD:  next_state = Mem_Ready ? S_MEMWB : S_MEMRD;
            S_MEMWB:  next_state = S_FETCH;
            S_MEMWR:  next_state = Mem_Ready ? S_FETCH : S_MEMWR;
            S_RTEXE:  next_state = r_legal ? S_ALUWB : illegal_next;
            S_ITEXE:  next_state = S_ALUWB;
            S_ALUWB:  next_state = ovf_trap ? S_EXC : S_FETCH;
            default:  next_state = S_FETCH;
        endcase
    end

    // Datapath controls decoded from the current state
    always_comb begin
        ALU_Func  = F_PASSB;
        ALUSrcA   = 1'b0;
        ALUSrcB   = 2'b00;
        ExtSel    = 1'b0;
        Mem_Read  = 1'b0;
        Mem_Write = 1'b0;
        IorD      = 1'b0;
        IR_Write  = 1'b0;
        PC_Write  = 1'b0;
        PC_Src    = 2'b00;
        Reg_Write = 1'b0;
        RegDst    = 1'b0;
        MemToReg  = 1'b0;
        EPC_Write = 1'b0;
        case (state)
            S_FETCH: begin
                Mem_Read = 1'b1;
                ALUSrcB  = 2'b01;
                ALU_Func = F_ADDU;
                IR_Write = Mem_Ready;
                PC_Write = Mem_Ready;
            end
            S_DECODE: begin
                ALUSrcB  = 2'b11;
                ExtSel   = 1'b1;
                ALU_Func = F_ADDU;
            end
            S_MEMADR: begin
                ALUSrcA  = 1'b1;
                ALUSrcB  = 2'b10;
                ExtSel   = 1'b1;
                ALU_Func = F_ADDU;
            end
            S_MEMRD: begin
                Mem_Read = 1'b1;
                IorD     = 1'b1;
            end
            S_MEMWB: begin
                Reg_Write = 1'b1;
                MemToReg  = 1'b1;
            end
            S_MEMWR: begin
                Mem_Write = 1'b1;
                IorD      = 1'b1;
            end
            S_RTEXE: begin
                ALUSrcA  = 1'b1;
                ALU_Func = r_func;
            end
            S_ITEXE: begin
                ALUSrcA  = 1'b1;
                ALUSrcB  = 2'b10;
                ExtSel   = i_ext;
                ALU_Func = i_func;
            end
            S_ALUWB: begin
                Reg_Write = ~ovf_trap;
                RegDst    = (opcode == OP_RTYPE);
            end
            S_BRANCH: begin
                ALUSrcA  = 1'b1;
                ALU_Func = F_SUBU;
                PC_Src   = 2'b01;
                PC_Write = (opcode == OP_BEQ) ? ALU_Zero : ~ALU_Zero;
            end
            S_JUMP: begin
                PC_Src   = 2'b10;
                PC_Write = 1'b1;
            end
            S_EXC: begin
                EPC_Write = 1'b1;
                PC_Write  = 1'b1;
                PC_Src    = 2'b11;
            end
            default: ;
        endcase
        // NOTE: reset gates the decoded outputs directly so pending memory requests drop the instant rst rises, not at the next edge.
        if (rst) begin
            ALU_Func  = F_PASSB;
            ALUSrcA   = 1'b0;
            ALUSrcB   = 2'b00;
            ExtSel    = 1'b0;
            Mem_Read  = 1'b0;
            Mem_Write = 1'b0;
            IorD      = 1'b0;
            IR_Write  = 1'b0;
            PC_Write  = 1'b0;
            PC_Src    = 2'b00;
            Reg_Write = 1'b0;
            RegDst    = 1'b0;
            MemToReg  = 1'b0;
            EPC_Write = 1'b0;
        end
    end

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Self-checking bench for mips_multicycle_ctrl. Each instruction is turned
// into the route of steps it must take; every cycle the DUT outputs are
// compared with the outputs that route step demands.
module tb_mips_multicycle_ctrl;

    localparam bit P_OVF = 1'b1;
    localparam bit P_ILL = 1'b1;

    localparam int S_FETCH = 0, S_DECODE = 1, S_MEMADR = 2, S_MEMRD = 3, S_MEMWB = 4,
                   S_MEMWR = 5, S_RTEXE = 6, S_ITEXE = 7, S_ALUWB = 8, S_BRANCH = 9,
                   S_JUMP = 10, S_EXC = 11;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] Instr;
    logic        ALU_Zero, ALU_OverFlow, Mem_Ready;
    logic [3:0]  ALU_Func;
    logic        ALUSrcA;
    logic [1:0]  ALUSrcB;
    logic        ExtSel, Mem_Read, Mem_Write, IorD, IR_Write, PC_Write;
    logic [1:0]  PC_Src;
    logic        Reg_Write, RegDst, MemToReg, EPC_Write;
    logic [1:0]  Exc_Cause;
    logic [3:0]  State;

    mips_multicycle_ctrl #(.EXC_ON_OVF(P_OVF), .EXC_ON_ILLEGAL(P_ILL)) dut (
        .clk(clk), .rst(rst), .Instr(Instr), .ALU_Zero(ALU_Zero),
        .ALU_OverFlow(ALU_OverFlow), .Mem_Ready(Mem_Ready), .ALU_Func(ALU_Func),
        .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ExtSel(ExtSel), .Mem_Read(Mem_Read),
        .Mem_Write(Mem_Write), .IorD(IorD), .IR_Write(IR_Write), .PC_Write(PC_Write),
        .PC_Src(PC_Src), .Reg_Write(Reg_Write), .RegDst(RegDst), .MemToReg(MemToReg),
        .EPC_Write(EPC_Write), .Exc_Cause(Exc_Cause), .State(State)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0] state;
        logic [1:0] cause;
        logic [3:0] func;
        logic       srca;
        logic [1:0] srcb;
        logic       ext, mrd, mwr, iord, irw, pcw;
        logic [1:0] pcsrc;
        logic       rw, rdst, m2r, epcw;
    } outs_t;

    int          checks = 0;
    int          errors = 0;
    int          cur;
    int          plan[$];
    logic        loaded;
    logic [31:0] cur_instr;
    logic        inst_ovf;
    logic [1:0]  exp_cause, pending_cause;
    logic [31:0] instr_q[$];
    outs_t       snap [0:11];
    int          mrd_cycles;
    int          cyc;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, req, $time);
        end
    endtask

    function automatic void r_info(input logic [5:0] f, output logic [3:0] func, output logic ok);
        ok = 1'b1;
        case (f)
            6'h20: func = 4'b0010;  6'h21: func = 4'b0001;
            6'h22: func = 4'b0100;  6'h23: func = 4'b0011;
            6'h24: func = 4'b0101;  6'h25: func = 4'b0110;
            6'h26: func = 4'b1000;  6'h27: func = 4'b0111;
            6'h2A: func = 4'b1010;  6'h2B: func = 4'b1001;
            default: begin func = 4'b0000; ok = 1'b0; end
        endcase
    endfunction

    function automatic void i_info(input logic [5:0] op, output logic [3:0] func,
                                   output logic ext, output logic ok);
        ok = 1'b1; ext = 1'b1; func = 4'b0001;
        case (op)
            6'h08: func = 4'b0010;
            6'h09: func = 4'b0001;
            6'h0C: begin func = 4'b0101; ext = 1'b0; end
            6'h0D: begin func = 4'b0110; ext = 1'b0; end
            6'h0E: begin func = 4'b1000; ext = 1'b0; end
            6'h0A: func = 4'b1010;
            6'h0B: func = 4'b1001;
            6'h0F: begin func = 4'b0000; ext = 1'b0; end
            default: ok = 1'b0;
        endcase
    endfunction

    // Route of steps following FETCH for one instruction
    task automatic build_plan(input logic [31:0] ins);
        logic [5:0] op;
        logic [3:0] f;
        logic ok, ext;
        op = ins[31:26];
        plan.delete();
        plan.push_back(S_DECODE);
        i_info(op, f, ext, ok);
        if (op == 6'h23) begin
            plan.push_back(S_MEMADR); plan.push_back(S_MEMRD); plan.push_back(S_MEMWB);
        end else if (op == 6'h2B) begin
            plan.push_back(S_MEMADR); plan.push_back(S_MEMWR);
        end else if (op == 6'h00) begin
            r_info(ins[5:0], f, ok);
            plan.push_back(S_RTEXE);
            if (ok) plan.push_back(S_ALUWB);
            else if (P_ILL) begin plan.push_back(S_EXC); pending_cause = 2'b10; end
        end else if (ok) begin
            plan.push_back(S_ITEXE); plan.push_back(S_ALUWB);
        end else if (op == 6'h04 || op == 6'h05) begin
            plan.push_back(S_BRANCH);
        end else if (op == 6'h02) begin
            plan.push_back(S_JUMP);
        end else if (P_ILL) begin
            plan.push_back(S_EXC); pending_cause = 2'b10;
        end
    endtask

    function automatic outs_t exp_outs(input int step, input logic [31:0] ins, input logic rdy,
                                       input logic z, input logic ovf, input logic [1:0] cause);
        outs_t e;
        logic [3:0] f;
        logic ok, ext;
        e = '0;
        e.state = 4'(step);
        e.cause = cause;
        case (step)
            S_FETCH:  begin e.mrd = 1; e.srcb = 2'b01; e.func = 4'b0001; e.irw = rdy; e.pcw = rdy; end
            S_DECODE: begin e.srcb = 2'b11; e.ext = 1; e.func = 4'b0001; end
            S_MEMADR: begin e.srca = 1; e.srcb = 2'b10; e.ext = 1; e.func = 4'b0001; end
            S_MEMRD:  begin e.mrd = 1; e.iord = 1; end
            S_MEMWB:  begin e.rw = 1; e.m2r = 1; end
            S_MEMWR:  begin e.mwr = 1; e.iord = 1; end
            S_RTEXE:  begin r_info(ins[5:0], f, ok); e.srca = 1; e.func = f; end
            S_ITEXE:  begin i_info(ins[31:26], f, ext, ok); e.srca = 1; e.srcb = 2'b10; e.ext = ext; e.func = f; end
            S_ALUWB:  begin e.rw = !(ovf && P_OVF); e.rdst = (ins[31:26] == 6'h00); end
            S_BRANCH: begin e.srca = 1; e.func = 4'b0011; e.pcsrc = 2'b01; e.pcw = (ins[31:26] == 6'h04) ? z : !z; end
            S_JUMP:   begin e.pcsrc = 2'b10; e.pcw = 1; end
            S_EXC:    begin e.epcw = 1; e.pcw = 1; e.pcsrc = 2'b11; end
            default: ;
        endcase
        return e;
    endfunction

    function automatic outs_t dut_outs();
        outs_t r;
        r.state = State;   r.cause = Exc_Cause; r.func = ALU_Func; r.srca = ALUSrcA;
        r.srcb = ALUSrcB;  r.ext = ExtSel;      r.mrd = Mem_Read;  r.mwr = Mem_Write;
        r.iord = IorD;     r.irw = IR_Write;    r.pcw = PC_Write;  r.pcsrc = PC_Src;
        r.rw = Reg_Write;  r.rdst = RegDst;     r.m2r = MemToReg;  r.epcw = EPC_Write;
        return r;
    endfunction

    function automatic logic [31:0] rand_instr();
        logic [5:0] ops [0:14] = '{6'h00, 6'h23, 6'h2B, 6'h08, 6'h09, 6'h0C, 6'h0D, 6'h0E,
                                   6'h0A, 6'h0B, 6'h0F, 6'h04, 6'h05, 6'h02, 6'h3F};
        logic [5:0] fns [0:9] = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27,
                                  6'h2A, 6'h2B};
        logic [31:0] r;
        logic [5:0]  op;
        r  = $urandom();
        op = ops[$urandom_range(0, 14)];
        if ($urandom_range(0, 9) == 0) op = 6'($urandom_range(0, 63));
        if (op == 6'h00 && $urandom_range(0, 5) != 0) r[5:0] = fns[$urandom_range(0, 9)];
        return {op, r[25:0]};
    endfunction

    task automatic model_reset();
        cur = S_FETCH; loaded = 1'b0; plan.delete();
        inst_ovf = 1'b0; exp_cause = 2'b00; pending_cause = 2'b00;
    endtask

    // One clock: drive at posedge+1, compare at the negedge, advance the route
    task automatic tick(input logic rdy, input logic z, input logic o);
        outs_t act, exp;
        if (cur == S_FETCH && !loaded) begin
            cur_instr = (instr_q.size() > 0) ? instr_q.pop_front() : rand_instr();
            Instr = cur_instr;
            build_plan(cur_instr);
            loaded = 1'b1;
            inst_ovf = 1'b0;
        end
        Mem_Ready = rdy; ALU_Zero = z; ALU_OverFlow = o;
        #4;
        act = dut_outs();
        exp = exp_outs(cur, cur_instr, rdy, z, inst_ovf, exp_cause);
        check($sformatf("outs step=%0d instr=%h", cur, cur_instr), 32'(act), 32'(exp));
        snap[cur] = act;
        if (cur == S_MEMRD && Mem_Read) mrd_cycles++;
        if (!((cur == S_FETCH || cur == S_MEMRD || cur == S_MEMWR) && !rdy)) begin
            if (cur == S_RTEXE || cur == S_ITEXE) begin
                inst_ovf = o && (exp.func == 4'b0010 || exp.func == 4'b0100);
                if (inst_ovf && P_OVF) begin plan.push_back(S_EXC); pending_cause = 2'b01; end
            end
            if (plan.size() == 0) begin
                cur = S_FETCH; loaded = 1'b0;
            end else begin
                cur = plan.pop_front();
                if (cur == S_EXC) exp_cause = pending_cause;
            end
        end
        @(posedge clk); #1;
    endtask

    // Run one whole instruction; memory steps stall for 'stall' cycles
    task automatic run_instr(input logic [31:0] ins, input int stall, input logic z,
                             input logic o, output int cycles);
        int stalls;
        logic r;
        instr_q.push_back(ins);
        cycles = 0; stalls = 0;
        while (cycles == 0 || (!(cur == S_FETCH && !loaded) && cycles < 60)) begin
            r = 1'b1;
            if ((cur == S_MEMRD || cur == S_MEMWR) && stalls < stall) begin r = 1'b0; stalls++; end
            tick(r, z, o);
            cycles++;
        end
        if (cycles >= 60) check($sformatf("timeout instr=%h", ins), 32'(cycles), 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; Instr = '0; ALU_Zero = 0; ALU_OverFlow = 0; Mem_Ready = 1;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check("outputs under reset", 32'(dut_outs()), 32'd0);
        rst = 1'b0;

        // addu $3,$1,$2: 4 cycles, writeback to rd
        run_instr(32'h0022_1821, 0, 1'b0, 1'b0, cyc);
        check("addu cycles", 32'(cyc), 32'd4);
        check("fetch IR_Write", 32'(snap[S_FETCH].irw), 32'd1);
        check("decode State", 32'(snap[S_DECODE].state), 32'd1);
        check("addu RTEXE func", 32'(snap[S_RTEXE].func), 32'b0001);
        check("addu ALUWB RegDst", 32'(snap[S_ALUWB].rdst), 32'd1);

        // add with overflow: no writeback, then exception with cause 01
        run_instr(32'h0022_1820, 0, 1'b0, 1'b1, cyc);
        check("add ovf cycles", 32'(cyc), 32'd5);
        check("add ovf Reg_Write", 32'(snap[S_ALUWB].rw), 32'd0);
        check("add ovf EPC_Write", 32'(snap[S_EXC].epcw), 32'd1);
        check("add ovf PC_Src", 32'(snap[S_EXC].pcsrc), 32'd3);
        check("add ovf cause", 32'(snap[S_EXC].cause), 32'd1);
        check("cause held", 32'(Exc_Cause), 32'd1);

        // lw with three not-ready cycles in MEMRD
        mrd_cycles = 0;
        run_instr(32'h8C22_0004, 3, 1'b0, 1'b0, cyc);
        check("lw cycles", 32'(cyc), 32'd8);
        check("lw Mem_Read cycles", 32'(mrd_cycles), 32'd4);
        check("lw IorD", 32'(snap[S_MEMRD].iord), 32'd1);
        check("lw MemToReg", 32'(snap[S_MEMWB].m2r), 32'd1);

        // branches with ALU_Zero=1
        run_instr(32'h1022_0003, 0, 1'b1, 1'b0, cyc);
        check("beq taken PC_Write", 32'(snap[S_BRANCH].pcw), 32'd1);
        check("beq PC_Src", 32'(snap[S_BRANCH].pcsrc), 32'd1);
        run_instr(32'h1422_0003, 0, 1'b1, 1'b0, cyc);
        check("bne not taken PC_Write", 32'(snap[S_BRANCH].pcw), 32'd0);

        // illegal opcode 0x3F
        run_instr(32'hFC00_0000, 0, 1'b0, 1'b0, cyc);
        check("illegal cycles", 32'(cyc), 32'd3);
        check("illegal cause", 32'(snap[S_EXC].cause), 32'd2);

        // reset in the middle of a stalled store
        instr_q.push_back(32'hAC22_0004);
        cyc = 0;
        tick(1'b1, 1'b0, 1'b0);
        while (cur != S_MEMWR && cyc < 10) begin tick(1'b1, 1'b0, 1'b0); cyc++; end
        tick(1'b0, 1'b0, 1'b0);
        Mem_Ready = 1'b0;
        #2;
        check("sw waiting Mem_Write", 32'(Mem_Write), 32'd1);
        check("cause before reset", 32'(Exc_Cause), 32'd2);
        rst = 1'b1;
        #1;
        check("reset drops Mem_Write", 32'(Mem_Write), 32'd0);
        check("reset State", 32'(State), 32'd0);
        check("reset Mem_Read", 32'(Mem_Read), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        model_reset();
        check("cause after reset", 32'(Exc_Cause), 32'd0);

        // randomized instruction stream
        for (int n = 0; n < 400; n++) begin
            int c;
            c = 0;
            tick($urandom_range(0, 2) != 0, 1'($urandom_range(0, 1)), $urandom_range(0, 3) == 0);
            c++;
            while (!(cur == S_FETCH && !loaded) && c < 60) begin
                tick($urandom_range(0, 2) != 0, 1'($urandom_range(0, 1)), $urandom_range(0, 3) == 0);
                c++;
            end
            if (c >= 60) check("random instr timeout", 32'(c), 32'd0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
